dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data memory responder for the MEM stage of the single-cycle/pipelined MIPS datapath. It accepts a word read or write request on the existing memread/memwrite/addr/write_data interface, services it after a fixed configurable latency, and answers with a one-cycle ack. It raises stall to freeze the pipeline while the access is outstanding. It sits between the MEM stage and backing word storage, and replaces the zero-latency data memory when realistic memory timing is modelled.

## Interface
- DEPTH, 256, number of 32-bit words; power of two
- LATENCY, 2, cycles from request acceptance to ack; integer ≥ 1
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- addr  input  32  word index (not byte address)
- write_data  input  32  store data
- memread  input  1  read request
- memwrite  input  1  write request
- read_data  output  32  registered load data; valid in ack cycle, held until next ack
- ack  output  1  one-cycle completion pulse
- stall  output  1  pipeline hold; high while a request is presented or outstanding
- addr_err  output  1  out-of-range flag; qualified by ack (see Configuration)

## Operation
- Request = memread | memwrite, sampled only in IDLE.
- Op decode: memwrite=1 → write (takes priority even when memread=1). Combined read+write returns the newly written data on read_data. memread only → read.
- FSM states:
  - IDLE: on request, capture addr, write_data, and op into internal registers; load counter with LATENCY-1; go to WAIT. If LATENCY=1, go straight to RESP.
  - WAIT: decrement counter each cycle; at 0, perform the storage access and go to RESP.
  - RESP: ack=1; go to IDLE. A request present during RESP is ignored and must be re-presented in IDLE.
- Captured values are used for the access. Inputs may change freely after the acceptance cycle.
- Read: read_data ← mem[idx], registered so it is visible in RESP.
- Write: mem[idx] ← write_data. For a pure write, read_data is unchanged.
- idx = addr[log2(DEPTH)-1:0].
- Storage is zero at time 0 and is not cleared by rst.
- stall = (IDLE & request & ~rst) | WAIT. It is combinational and low in RESP.

## Timing
- Acceptance cycle = cycle 0. ack high in cycle LATENCY only. stall high in cycles 0..LATENCY-1.
- Back-to-back requests: the next acceptance happens no earlier than cycle LATENCY+1.
- Reset values: state IDLE, read_data=0, ack=0, stall=0, addr_err=0, counter=0.
- Reset mid-operation (rst high in WAIT or RESP): the pending access is aborted and no ack is issued. A write that has not yet reached its access edge must not modify storage. If rst coincides with the access edge, reset wins and no write occurs.
- While rst is high, requests are ignored.

## Configuration
- DMEM_ERR_EN defined:
  - Range check on the captured addr: addr ≥ DEPTH sets addr_err=1 in the ack cycle.
  - An out-of-range write is suppressed; an out-of-range read returns read_data=0.
  - addr_err is 0 in all other cycles.
- DMEM_ERR_EN undefined:
  - addr_err is tied to 0.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH.

## Test plan
- Reset: rst=1 for 2 cycles with memread=1 → read_data=0, ack=0, stall=0, addr_err=0 throughout.
- Write then read (LATENCY=2): memwrite, addr=1, write_data=0xFFFFFFFE → stall high in cycles 0–1, ack in cycle 2. Then memread, addr=1 → ack in cycle 2 of the new request with read_data=0xFFFFFFFE.
- Combined read+write: memread=memwrite=1, addr=2, write_data=0xFFFFFFFD → ack with read_data=0xFFFFFFFD. A later read of addr 2 returns 0xFFFFFFFD.
- Input change during WAIT: write accepted at addr=4, write_data=0xFFFFFFFB, then addr changes to 8 in cycle 1 → word 4 = 0xFFFFFFFB, word 8 unchanged.
- Out of range: addr=0x100, write_data=0x12345678.
  - With DMEM_ERR_EN: ack with addr_err=1; a subsequent read of addr 0 returns 0 (word 0 untouched).
  - Without the macro: word 0 becomes 0x12345678 and addr_err stays 0.
- Reset mid-write: write to addr=8, data=0xFFFFFFF7, rst pulsed in cycle 1 → no ack; a read of addr 8 after reset returns the prior value (0).

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory responder with stall/ack handshake
//
// Purpose: services one word read or write per request after a fixed LATENCY,
//          pulses ack for one cycle on completion and holds the pipeline via stall
//          while the access is in flight.
// Build option: define DMEM_ERR_EN to enable address range checking (addr_err,
//               write suppression and zero read data for addr >= DEPTH).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   addr              word index of the request
//   write_data        store data
//   memread/memwrite  request strobes (write wins when both are set)
//   read_data         registered load data, held until the next load completes
//   ack               one-cycle completion pulse
//   stall             combinational pipeline hold
//   addr_err          out-of-range flag, valid with ack
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        memread,
   input  logic        memwrite,
   output logic [31:0] read_data,
   output logic        ack,
   output logic        stall,
   output logic        addr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic          r_op_rd;
   logic          r_op_wr;
   logic          r_oob;

   logic [31:0]   r_mem [DEPTH];

   logic          w_req;
   logic          w_in_oob;
   logic          w_acc_en;
   logic          w_acc_rd;
   logic          w_acc_wr;
   logic          w_acc_oob;
   logic [AW-1:0] w_acc_idx;
   logic [31:0]   w_acc_wdata;
   logic [31:0]   w_mem_rdata;
   logic          w_mem_we;

   assign w_req = memread | memwrite;

`ifdef DMEM_ERR_EN
   assign w_in_oob = (addr >= 32'(DEPTH));
`else
   // Upper address bits are intentionally dropped so addresses wrap.
   logic w_unused_addr;
   assign w_unused_addr = &{1'b0, addr[31:AW]};
   assign w_in_oob      = 1'b0;
`endif

   // With a single-cycle latency the access happens on the acceptance edge,
   // so it must use the live inputs; otherwise it uses the captured request
   // on the last WAIT edge (counter about to reach zero).
   always_comb begin
      w_acc_en    = 1'b0;
      w_acc_rd    = r_op_rd;
      w_acc_wr    = r_op_wr;
      w_acc_oob   = r_oob;
      w_acc_idx   = r_idx;
      w_acc_wdata = r_wdata;
      if (LATENCY == 1) begin
         w_acc_en    = (r_state == ST_IDLE) && w_req;
         w_acc_rd    = memread;
         w_acc_wr    = memwrite;
         w_acc_oob   = w_in_oob;
         w_acc_idx   = addr[AW-1:0];
         w_acc_wdata = write_data;
      end else begin
         w_acc_en = (r_state == ST_WAIT) && (r_cnt == CW'(1));
      end
   end

   // Reset on the access edge wins: the store is gated off.
   assign w_mem_we    = w_acc_en & w_acc_wr & ~w_acc_oob & ~rst;
   assign w_mem_rdata = r_mem[w_acc_idx];

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_acc_idx] <= w_acc_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_op_rd   <= 1'b0;
         r_op_wr   <= 1'b0;
         r_oob     <= 1'b0;
         read_data <= '0;
         ack       <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         ack      <= 1'b0;
         addr_err <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_idx   <= addr[AW-1:0];
                  r_wdata <= write_data;
                  r_op_rd <= memread;
                  r_op_wr <= memwrite;
                  r_oob   <= w_in_oob;
                  r_cnt   <= CNT_LOAD;
                  r_state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Requests seen here are dropped; the master re-presents in IDLE.
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         if (w_acc_en) begin
            ack      <= 1'b1;
            addr_err <= w_acc_oob;
            // Combined read+write forwards the store data; a pure write
            // leaves read_data untouched.
            if (w_acc_wr && w_acc_rd) begin
               read_data <= w_acc_oob ? 32'd0 : w_acc_wdata;
            end else if (!w_acc_wr) begin
               read_data <= w_acc_oob ? 32'd0 : w_mem_rdata;
            end
         end
      end
   end

   assign stall = ((r_state == ST_IDLE) && w_req && !rst) || (r_state == ST_WAIT);

endmodule
